// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: PC, pipelined memory requests, in-order instruction queue
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect enqueues an exception entry and halts fetch.
module if_fetch #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        excp_o
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] PF_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);
  localparam logic [CW-1:0] MAXO_W  = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d, outst_q, outst_d, discard_q, discard_d;
  logic [PW-1:0] pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;

  logic [31:0] pf_pc  [MAX_OUTSTANDING];
  logic [31:0] q_pc   [DEPTH];
  logic [31:0] q_inst [DEPTH];

  logic          gnt, drop, push, pop, halted;
  logic          q_we;
  logic [AW-1:0] q_widx;
  logic [31:0]   q_wpc, q_winst;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halted_q, halted_d;
  logic q_wexcp;
  logic q_excp [DEPTH];
  assign halted = halted_q;
  assign excp_o = valid_o && q_excp[rd_ptr_q];
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^redirect_pc_i[1:0];
  assign halted = 1'b0;
  assign excp_o = 1'b0;
`endif

  // Credit check counts in-flight requests so a returning response always has a slot.
  assign mem_req_o  = rst && !redirect_i && !halted &&
                      (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W) && (outst_q < MAXO_W);
  assign mem_addr_o = fetch_pc_q;
  assign gnt        = mem_req_o && mem_gnt_i;
  assign drop       = discard_q != '0;
  assign push       = mem_rvalid_i && !drop && !redirect_i;
  assign valid_o    = count_q != '0;
  assign pop        = valid_o && ready_i && !redirect_i;
  assign pc_o       = valid_o ? q_pc[rd_ptr_q] : 32'h0;
  assign inst_o     = valid_o ? q_inst[rd_ptr_q] : 32'h0;

  always_comb begin
    fetch_pc_d = gnt ? fetch_pc_q + 32'd4 : fetch_pc_q;
    outst_d    = outst_q + CW'(gnt) - CW'(mem_rvalid_i);
    discard_d  = discard_q - CW'(mem_rvalid_i && drop);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(pop);
    pf_wr_d    = gnt ? ((pf_wr_q == PF_LAST) ? '0 : pf_wr_q + 1'b1) : pf_wr_q;
    pf_rd_d    = (mem_rvalid_i && !drop) ? ((pf_rd_q == PF_LAST) ? '0 : pf_rd_q + 1'b1) : pf_rd_q;
    q_we       = push;
    q_widx     = wr_ptr_q;
    q_wpc      = pf_pc[pf_rd_q];
    q_winst    = mem_rdata_i;
`ifdef FETCH_ALIGN_CHECK_EN
    q_wexcp    = 1'b0;
    halted_d   = halted_q;
`endif
    if (redirect_i) begin
      // Everything still in flight after this cycle's response must be dropped on return.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      discard_d  = outst_d;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pf_rd_d    = '0;
      pf_wr_d    = '0;
      q_we       = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      halted_d   = 1'b0;
      if (redirect_pc_i[1:0] != 2'b00) begin
        fetch_pc_d = redirect_pc_i;
        q_we       = 1'b1;
        q_widx     = '0;
        q_wpc      = redirect_pc_i;
        q_winst    = 32'h0;
        q_wexcp    = 1'b1;
        wr_ptr_d   = AW'(1);
        count_d    = CW'(1);
        halted_d   = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      pf_rd_q    <= '0;
      pf_wr_q    <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      pf_rd_q    <= pf_rd_d;
      pf_wr_q    <= pf_wr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      halted_q   <= halted_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (gnt) pf_pc[pf_wr_q] <= fetch_pc_q;
    if (q_we) begin
      q_pc[q_widx]   <= q_wpc;
      q_inst[q_widx] <= q_winst;
`ifdef FETCH_ALIGN_CHECK_EN
      q_excp[q_widx] <= q_wexcp;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - randomized bench for if_fetch against a queue-level fetch model
// Directed checks cover reset, stalls, redirects, address wrap and FETCH_ALIGN_CHECK_EN.
module tb_if_fetch;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam logic [31:0] SALT = 32'h5A5A_0F0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_o, mem_gnt_i, mem_rvalid_i, redirect_i, valid_o, ready_i, excp_o;
  logic [31:0] mem_addr_o, mem_rdata_i, redirect_pc_i, pc_o, inst_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .inst_o(inst_o), .excp_o(excp_o)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] pcq[$];
  logic [31:0] memq[$];
  int          outst, disc, grants;
  logic [31:0] fpc;
  bit          halted;
  bit          s_dgnt;
  logic [31:0] s_daddr;
  int          total, bad;
  bit          o_req, o_valid, o_excp;
  logic [31:0] o_addr, o_pc, o_inst;

  function automatic bit model_req();
    return rst && !redirect_i && !halted && (mq.size() + outst < DEPTH) && (outst < MAXO);
  endfunction

  // Memory (in-order responder) and fetch model both advance on the clock edge.
  always @(posedge clk or negedge rst) begin : model
    bit   granted;
    ent_t e;
    if (!rst) begin
      mq.delete(); pcq.delete(); memq.delete();
      outst = 0; disc = 0; fpc = 32'h0; halted = 0;
    end else begin
      granted = model_req() && mem_gnt_i;
      if (mem_rvalid_i && memq.size() > 0) void'(memq.pop_front());
      if (s_dgnt) begin memq.push_back(s_daddr); grants++; end
      if (redirect_i) begin
        if (mem_rvalid_i) outst--;
        disc = outst;
        mq.delete(); pcq.delete();
        halted = 0;
`ifdef FETCH_ALIGN_CHECK_EN
        fpc = redirect_pc_i;
        if (redirect_pc_i[1:0] != 2'b00) begin
          e.pc = redirect_pc_i; e.inst = 32'h0; e.excp = 1'b1;
          mq.push_back(e);
          halted = 1;
        end
`else
        fpc = {redirect_pc_i[31:2], 2'b00};
`endif
      end else begin
        if (mq.size() > 0 && ready_i) void'(mq.pop_front());
        if (mem_rvalid_i) begin
          outst--;
          if (disc > 0) disc--;
          else begin
            if (pcq.size() > 0) e.pc = pcq.pop_front();
            else e.pc = 32'hDEAD_BEEF;
            e.inst = mem_rdata_i; e.excp = 1'b0;
            mq.push_back(e);
          end
        end
        if (granted) begin pcq.push_back(fpc); fpc = fpc + 32'd4; outst++; end
      end
    end
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit mreq;
    mreq = model_req();
    chk1("mem_req_o", mem_req_o, mreq);
    if (mreq) chk32("mem_addr_o", mem_addr_o, fpc);
    chk1("valid_o", valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      chk32("pc_o", pc_o, mq[0].pc);
      chk32("inst_o", inst_o, mq[0].inst);
      chk1("excp_o", excp_o, mq[0].excp);
    end
  endtask

  task automatic drive(input int gp, input int rp, input int dp, input bit redir, input logic [31:0] rpc);
    mem_gnt_i = int'($urandom_range(99)) < gp;
    if (memq.size() > 0 && int'($urandom_range(99)) < rp) begin
      mem_rvalid_i = 1'b1; mem_rdata_i = memq[0] ^ SALT;
    end else begin
      mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
    end
    ready_i       = int'($urandom_range(99)) < dp;
    redirect_i    = redir;
    redirect_pc_i = redir ? rpc : $urandom;
  endtask

  task automatic cycle(input int gp, input int rp, input int dp, input bit redir, input logic [31:0] rpc);
    drive(gp, rp, dp, redir, rpc);
    @(negedge clk);
    o_req = mem_req_o; o_addr = mem_addr_o; o_valid = valid_o;
    o_pc = pc_o; o_inst = inst_o; o_excp = excp_o;
    s_dgnt = mem_req_o && mem_gnt_i; s_daddr = mem_addr_o;
    compare_model();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (8) cycle(0, 100, 100, 1'b0, 32'h0);
  endtask

  task automatic wait_valid(input int gp, input int rp, input int dp, input string name);
    int n;
    n = 0;
    do begin cycle(gp, rp, dp, 1'b0, 32'h0); n++; end while (!o_valid && n < 20);
    chk1(name, o_valid, 1'b1);
  endtask

  task automatic check_reset_values();
    chk1("reset mem_req_o", mem_req_o, 1'b0);
    chk32("reset mem_addr_o", mem_addr_o, 32'h0);
    chk1("reset valid_o", valid_o, 1'b0);
    chk32("reset pc_o", pc_o, 32'h0);
    chk32("reset inst_o", inst_o, 32'h0);
    chk1("reset excp_o", excp_o, 1'b0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      bit          r;
      logic [31:0] p;
      r = $urandom_range(99) < 4;
      if ($urandom_range(9) == 0) p = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(3)), 2'b00};
      else p = $urandom & 32'h0000_FFFF;
      if ($urandom_range(3) != 0) p[1:0] = 2'b00;
      cycle(70, 60, 60, r, p);
    end
  endtask

  logic [31:0] seq_exp [4];
  int          g0;

  initial begin
    total = 0; bad = 0; grants = 0;
    s_dgnt = 0; s_daddr = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    redirect_i = 0; redirect_pc_i = 0; ready_i = 0;
    seq_exp[0] = 32'h0; seq_exp[1] = 32'h4; seq_exp[2] = 32'h8; seq_exp[3] = 32'hC;
    #1 rst = 1'b0;
    #1 check_reset_values();
    repeat (3) cycle(100, 100, 100, 1'b0, 32'h0);
    rst = 1'b1;

    // Single-cycle memory, decode always ready: pc_o 0,4,8,C from cycle 3.
    for (int i = 1; i <= 6; i++) begin
      cycle(100, 100, 100, 1'b0, 32'h0);
      if (i < 3) chk1("startup valid_o low", o_valid, 1'b0);
      else begin
        chk1("stream valid_o", o_valid, 1'b1);
        chk32("stream pc_o", o_pc, seq_exp[i-3]);
      end
    end

    // Decode stalled: exactly DEPTH grants, then requests resume after the first pop.
    drain();
    g0 = grants;
    cycle(100, 100, 0, 1'b1, 32'h1000);
    repeat (12) cycle(100, 100, 0, 1'b0, 32'h0);
    chk32("grants while stalled", 32'(grants - g0), 32'd4);
    chk1("req off when full", o_req, 1'b0);
    cycle(100, 100, 100, 1'b0, 32'h0);
    chk1("req off in pop cycle", o_req, 1'b0);
    chk1("valid in pop cycle", o_valid, 1'b1);
    cycle(100, 100, 0, 1'b0, 32'h0);
    chk1("req resumes after pop", o_req, 1'b1);

    // Two in flight, redirect: both old responses dropped.
    drain();
    cycle(100, 0, 100, 1'b1, 32'h40);
    repeat (2) cycle(100, 0, 100, 1'b0, 32'h0);
    cycle(100, 0, 100, 1'b1, 32'h100);
    chk1("req low in redirect cycle", o_req, 1'b0);
    wait_valid(100, 100, 100, "redirect 100 valid");
    chk32("redirect 100 pc", o_pc, 32'h100);
    chk32("redirect 100 inst", o_inst, 32'h100 ^ SALT);

    // Redirect coinciding with gnt and rvalid.
    drain();
    cycle(0, 0, 100, 1'b1, 32'h300);
    repeat (2) cycle(100, 0, 100, 1'b0, 32'h0);
    cycle(100, 100, 100, 1'b1, 32'h400);
    chk1("no grant in redirect cycle", o_req, 1'b0);
    wait_valid(100, 100, 0, "redirect 400 valid");
    chk32("redirect 400 pc", o_pc, 32'h400);
    chk32("redirect 400 inst", o_inst, 32'h400 ^ SALT);

    // Address wrap.
    drain();
    cycle(0, 100, 100, 1'b1, 32'hFFFF_FFF8);
    cycle(100, 100, 100, 1'b0, 32'h0);
    chk32("wrap addr 0", o_addr, 32'hFFFF_FFF8);
    cycle(100, 100, 100, 1'b0, 32'h0);
    chk32("wrap addr 1", o_addr, 32'hFFFF_FFFC);
    cycle(100, 100, 100, 1'b0, 32'h0);
    chk1("wrap req", o_req, 1'b1);
    chk32("wrap addr 2", o_addr, 32'h0000_0000);

    // Misaligned redirect.
    drain();
    cycle(100, 100, 100, 1'b1, 32'h102);
`ifdef FETCH_ALIGN_CHECK_EN
    cycle(100, 100, 0, 1'b0, 32'h0);
    chk1("align valid_o", o_valid, 1'b1);
    chk1("align excp_o", o_excp, 1'b1);
    chk32("align pc_o", o_pc, 32'h102);
    chk32("align inst_o", o_inst, 32'h0);
    chk1("align no req", o_req, 1'b0);
    repeat (3) begin
      cycle(100, 100, 100, 1'b0, 32'h0);
      chk1("halted no req", o_req, 1'b0);
    end
    cycle(100, 100, 100, 1'b1, 32'h200);
    cycle(100, 100, 100, 1'b0, 32'h0);
    chk1("unhalt req", o_req, 1'b1);
    chk32("unhalt addr", o_addr, 32'h200);
`else
    cycle(100, 100, 100, 1'b0, 32'h0);
    chk1("forced-align req", o_req, 1'b1);
    chk32("forced-align addr", o_addr, 32'h100);
    wait_valid(100, 100, 100, "forced-align valid");
    chk32("forced-align pc", o_pc, 32'h100);
    chk1("forced-align excp", o_excp, 1'b0);
`endif

    random_run(3000);

    // Asynchronous reset mid-operation.
    rst = 1'b0;
    #1 check_reset_values();
    repeat (2) cycle(70, 60, 60, 1'b0, 32'h0);
    rst = 1'b1;
    random_run(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
